// File: rtl/intr_pkg.sv
// Shared types and defaults for the interrupt arbiter slice.
package intr_pkg;

  localparam int N_SRC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

endpackage

// File: rtl/intr_edge_det.sv
// Rising-edge detector for a bank of synchronous lines. History resets to ones
// so that lines already high when reset is released do not register as edges.
module intr_edge_det #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] sig,
  output logic [W-1:0] rise
);

  logic [W-1:0] hist_r;

  // Previous-cycle copy of the input lines.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hist_r <= {W{1'b1}};
    end else begin
      hist_r <= sig;
    end
  end

  assign rise = sig & ~hist_r;

endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter: captures rising edges into pending requests, masks them,
// and runs the request/acknowledge/return handshake with the CPU.
module intr_arbiter
  import intr_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [N_SRC-1:0] irq,
  input  logic             mask_ld,
  input  logic [N_SRC-1:0] mask_in,
  input  logic             int_en,
  input  logic             int_ack,
  input  logic             int_ret,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  intr_state_t      state_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [ID_W-1:0]  int_id_r;
  logic             int_req_r;

  logic [N_SRC-1:0] rise_s;
  logic [N_SRC-1:0] cand_s;
  logic [N_SRC-1:0] ack_clr_s;
  logic [ID_W-1:0]  sel_s;

  intr_edge_det #(.W(N_SRC)) u_edge (
    .clk   (clk),
    .clr_n (clr_n),
    .sig   (irq),
    .rise  (rise_s)
  );

  assign cand_s = pending_r & mask_r;

  // Lowest-index candidate wins; scanning downward lets the lowest hit overwrite.
  always_comb begin
    sel_s = {ID_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      sel_s = cand_s[i] ? ID_W'(i) : sel_s;
    end
  end

  // Bit to clear when the CPU acknowledges the current request.
  always_comb begin
    ack_clr_s = {N_SRC{1'b0}};
    if ((state_r == REQ) && int_ack) begin
      ack_clr_s = {{(N_SRC-1){1'b0}}, 1'b1} << int_id_r;
    end else begin
      ack_clr_s = {N_SRC{1'b0}};
    end
  end

  // Pending and mask registers; a new edge overrides a same-cycle acknowledge clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pending_r <= {N_SRC{1'b0}};
      mask_r    <= {N_SRC{1'b0}};
    end else begin
      pending_r <= (pending_r & ~ack_clr_s) | rise_s;
      if (mask_ld) begin
        mask_r <= mask_in;
      end
    end
  end

  // Handshake FSM with registered request and latched source ID.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r   <= IDLE;
      int_id_r  <= {ID_W{1'b0}};
      int_req_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (int_en && (cand_s != {N_SRC{1'b0}})) begin
            state_r   <= REQ;
            int_id_r  <= sel_s;
            int_req_r <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_r   <= SERVICE;
            int_req_r <= 1'b0;
          end else if (!int_en || !mask_r[int_id_r]) begin
            state_r   <= IDLE;
            int_req_r <= 1'b0;
          end
        end
        SERVICE: begin
          int_req_r <= 1'b0;
          if (int_ret) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          int_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign int_req = int_req_r;
  assign int_id  = int_id_r;
  assign pending = pending_r;
  assign mask    = mask_r;

endmodule

// File: tb/tb_intr_arbiter.sv
// Self-checking bench for intr_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_intr_arbiter;

  localparam int N = 4;
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic [N-1:0] irq = 4'b0000;
  logic         mask_ld = 1'b0;
  logic [N-1:0] mask_in = 4'b0000;
  logic         int_en = 1'b0;
  logic         int_ack = 1'b0;
  logic         int_ret = 1'b0;
  logic         int_req;
  logic [1:0]   int_id;
  logic [N-1:0] pending;
  logic [N-1:0] mask;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int           m_st;
  int           m_id;
  logic [N-1:0] m_pend, m_mask, m_irq_q;

  intr_arbiter #(.N_SRC(N)) dut (
    .clk(clk), .clr_n(clr_n), .irq(irq), .mask_ld(mask_ld), .mask_in(mask_in),
    .int_en(int_en), .int_ack(int_ack), .int_ret(int_ret),
    .int_req(int_req), .int_id(int_id), .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_id = 0; m_pend = '0; m_mask = '0; m_irq_q = '1;
  endtask

  // One clock edge of the arbitration rules, evaluated on pre-edge values.
  task automatic model_edge();
    logic [N-1:0] rise, cand, np;
    int sel, nst, nid;
    rise = irq & ~m_irq_q;
    cand = m_pend & m_mask;
    sel = 0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin sel = i; break; end
    end
    np = m_pend;
    if (m_st == M_REQ && int_ack) np[m_id] = 1'b0;
    np = np | rise;
    nst = m_st; nid = m_id;
    if (m_st == M_IDLE) begin
      if (int_en && cand != 0) begin nst = M_REQ; nid = sel; end
    end else if (m_st == M_REQ) begin
      if (int_ack) nst = M_SVC;
      else if (!int_en || !m_mask[m_id]) nst = M_IDLE;
    end else begin
      if (int_ret) nst = M_IDLE;
    end
    if (mask_ld) m_mask = mask_in;
    m_pend = np; m_st = nst; m_id = nid; m_irq_q = irq;
  endtask

  task automatic compare_all();
    check("int_req", 32'(int_req), 32'(m_st == M_REQ));
    check("int_id",  32'(int_id),  32'(m_id));
    check("pending", 32'(pending), 32'(m_pend));
    check("mask",    32'(mask),    32'(m_mask));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    clr_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    int_ret = 1'b1; step(); int_ret = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset release with irq[1] already high
    irq = 4'b0010; int_en = 1'b1;
    #2;
    compare_all();
    @(negedge clk);
    clr_n = 1'b1;
    mask_ld = 1'b1; mask_in = 4'hF; step(); mask_ld = 1'b0;
    step(); step();
    check("rst_hi_pending", 32'(pending), 32'h0);
    check("rst_hi_req", 32'(int_req), 32'h0);
    irq = 4'b0000; step();
    irq = 4'b0010; step();
    check("edge_pending", 32'(pending), 32'h2);
    step();
    check("edge_req", 32'(int_req), 32'h1);
    check("edge_id", 32'(int_id), 32'h1);
    pulse_ack(); pulse_ret();
    irq = 4'b0000; step();

    // Priority between simultaneous edges
    irq = 4'b1010; step(); step();
    check("prio_id", 32'(int_id), 32'h1);
    pulse_ack();
    check("prio_pend", 32'(pending), 32'h8);
    pulse_ret(); step();
    check("prio_id3", 32'(int_id), 32'h3);
    check("prio_req3", 32'(int_req), 32'h1);
    pulse_ack(); pulse_ret();
    irq = 4'b0000; step();

    // Masking holds the request off until the mask opens
    mask_ld = 1'b1; mask_in = 4'b1110; step(); mask_ld = 1'b0;
    irq = 4'b0001; step(); step();
    check("mask_pend", 32'(pending), 32'h1);
    check("mask_req", 32'(int_req), 32'h0);
    mask_ld = 1'b1; mask_in = 4'hF; step(); mask_ld = 1'b0;
    step();
    check("unmask_req", 32'(int_req), 32'h1);
    check("unmask_id", 32'(int_id), 32'h0);

    // Enable drop while requesting
    int_en = 1'b0; step();
    check("endrop_req", 32'(int_req), 32'h0);
    check("endrop_pend", 32'(pending), 32'h1);
    int_en = 1'b1; step();
    check("enback_req", 32'(int_req), 32'h1);
    check("enback_id", 32'(int_id), 32'h0);
    pulse_ack(); pulse_ret();
    irq = 4'b0000; step();

    // New edge in the same cycle as the acknowledge of that source
    irq = 4'b0100; step(); step();
    check("sim_id", 32'(int_id), 32'h2);
    irq = 4'b0000; step();
    irq = 4'b0100; pulse_ack();
    check("sim_pend", 32'(pending[2]), 32'h1);
    pulse_ret(); step();
    check("sim_req2", 32'(int_req), 32'h1);
    check("sim_id2", 32'(int_id), 32'h2);

    // Reset in SERVICE, then a stray return
    pulse_ack();
    async_reset();
    check("rst_req", 32'(int_req), 32'h0);
    check("rst_pend", 32'(pending), 32'h0);
    pulse_ret(); step();
    check("rst_ret_req", 32'(int_req), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 99) < 15) irq[b] = ~irq[b];
      end
      mask_ld = ($urandom_range(0, 99) < 8);
      mask_in = 4'($urandom);
      int_en  = ($urandom_range(0, 99) < 90);
      int_ack = ($urandom_range(0, 99) < 30);
      int_ret = ($urandom_range(0, 99) < 30);
      step();
      if ($urandom_range(0, 999) < 3) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
